// File: rtl/pulp_l2_responder.sv
// Two-channel uDMA L2 responder: round-robin arbitration onto one single-port
// memory, TCDM-style handshake, error data and a saturating error counter.
module pulp_l2_responder #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,

  input  logic                      L2_ro_req_i,
  input  logic                      L2_ro_wen_i,
  input  logic [31:0]               L2_ro_addr_i,
  input  logic [DATA_WIDTH-1:0]     L2_ro_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   L2_ro_be_i,
  output logic                      L2_ro_gnt_o,
  output logic                      L2_ro_rvalid_o,
  output logic [DATA_WIDTH-1:0]     L2_ro_rdata_o,

  input  logic                      L2_wo_req_i,
  input  logic                      L2_wo_wen_i,
  input  logic [31:0]               L2_wo_addr_i,
  input  logic [DATA_WIDTH-1:0]     L2_wo_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   L2_wo_be_i,
  output logic                      L2_wo_gnt_o,
  output logic                      L2_wo_rvalid_o,
  output logic [DATA_WIDTH-1:0]     L2_wo_rdata_o,

  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic                      mem_gnt_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

  output logic [15:0]               err_cnt_o,
  input  logic                      err_clr_i
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [32:0] LIMIT     = 33'(BASE_ADDR) + (33'd4 << MEM_ADDR_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5);

  logic                  last_wo_q, last_wo_d;
  logic                  rvalid_ro_q, rvalid_ro_d;
  logic                  rvalid_wo_q, rvalid_wo_d;
  logic                  rd_q, rd_d;
  logic                  oor_q, oor_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic                  sel_ro, sel_req, sel_wen, in_range, granted;
  logic [31:0]           sel_addr, offset;
  logic [DATA_WIDTH-1:0] sel_wdata, resp_data;
  logic [BE_WIDTH-1:0]   sel_be;

  // Arbitration, memory request and next-state logic
  always_comb begin
    L2_ro_gnt_o = 1'b0;
    L2_wo_gnt_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    last_wo_d   = last_wo_q;
    err_cnt_d   = err_cnt_q;

    // Ties go to the channel that was not granted last
    sel_ro    = L2_ro_req_i & (~L2_wo_req_i | last_wo_q);
    sel_req   = L2_ro_req_i | L2_wo_req_i;
    sel_wen   = sel_ro ? L2_ro_wen_i   : L2_wo_wen_i;
    sel_addr  = sel_ro ? L2_ro_addr_i  : L2_wo_addr_i;
    sel_wdata = sel_ro ? L2_ro_wdata_i : L2_wo_wdata_i;
    sel_be    = sel_ro ? L2_ro_be_i    : L2_wo_be_i;

    in_range = ({1'b0, sel_addr} >= 33'(BASE_ADDR)) && ({1'b0, sel_addr} < LIMIT);
    offset   = sel_addr - BASE_ADDR;
    granted  = ~sys_rst_i & sel_req & (~in_range | mem_gnt_i);

    if (~sys_rst_i & sel_req & in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = ~sel_wen;
      mem_addr_o  = MEM_ADDR_WIDTH'(offset >> 2);
      mem_wdata_o = sel_wdata;
      mem_be_o    = sel_be;
    end

    L2_ro_gnt_o = granted & sel_ro;
    L2_wo_gnt_o = granted & ~sel_ro;

    rvalid_ro_d = granted & sel_ro;
    rvalid_wo_d = granted & ~sel_ro;
    rd_d        = sel_wen;
    oor_d       = ~in_range;

    if (granted) begin
      last_wo_d = ~sel_ro;
    end

    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (granted && !in_range && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      last_wo_q   <= 1'b1;
      rvalid_ro_q <= 1'b0;
      rvalid_wo_q <= 1'b0;
      rd_q        <= 1'b0;
      oor_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      last_wo_q   <= last_wo_d;
      rvalid_ro_q <= rvalid_ro_d;
      rvalid_wo_q <= rvalid_wo_d;
      rd_q        <= rd_d;
      oor_q       <= oor_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Response path: memory data is only valid in the cycle after the grant
  always_comb begin
    resp_data      = rd_q ? (oor_q ? ERR_DATA : mem_rdata_i) : '0;
    L2_ro_rvalid_o = rvalid_ro_q & ~sys_rst_i;
    L2_wo_rvalid_o = rvalid_wo_q & ~sys_rst_i;
    L2_ro_rdata_o  = L2_ro_rvalid_o ? resp_data : '0;
    L2_wo_rdata_o  = L2_wo_rvalid_o ? resp_data : '0;
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: doc/pulp_l2_responder.md
PULP_L2_RESPONDER -- requirements
Module: pulp_l2_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data width of both uDMA L2 ports and the memory port.
REQ-002 Parameter MEM_ADDR_WIDTH, default 16: word-address width of the backing memory.
REQ-003 Parameter BASE_ADDR, default 32'h1C00_0000: byte address that maps to memory word 0.
REQ-004 sys_clk_i  in  1  single clock for the whole block.
REQ-005 sys_rst_i  in  1  reset, synchronous, active-high.
REQ-006 L2_ro_req_i, L2_ro_wen_i  in  1 each  read-only-channel request; wen active-low (0 = write).
REQ-007 L2_ro_addr_i  in  32  byte address. L2_ro_wdata_i  in  DATA_WIDTH. L2_ro_be_i  in  DATA_WIDTH/8.
REQ-008 L2_ro_gnt_o, L2_ro_rvalid_o  out  1 each. L2_ro_rdata_o  out  DATA_WIDTH.
REQ-009 L2_wo_* ports: same set, widths and meaning as REQ-006..REQ-008, for the write-only channel.
REQ-010 mem_req_o, mem_we_o  out  1 each  single-port memory request and write enable (active-high).
REQ-011 mem_addr_o  out  MEM_ADDR_WIDTH. mem_wdata_o  out  DATA_WIDTH. mem_be_o  out  DATA_WIDTH/8.
REQ-012 mem_gnt_i  in  1  memory accepts a request this cycle.
REQ-013 mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after an accepted read.
REQ-014 err_cnt_o  out  16  count of out-of-range accesses. err_clr_i  in  1  clears the count.

Function
REQ-015 Each channel SHALL follow the TCDM handshake: gnt_o is asserted combinationally in the same cycle as req_i, and rvalid_o SHALL pulse exactly one cycle after each granted request, for reads and writes alike.
REQ-016 Out of reset, and whenever no other rule applies, all outputs SHALL be 0.
REQ-017 Arbitration: at most one channel is granted per cycle; with a single requester that channel is selected.
REQ-018 When both channels request, the channel not granted most recently SHALL be selected (round-robin); a 1-bit last-grant pointer updates only on a grant.
REQ-019 In range = BASE_ADDR <= addr < BASE_ADDR + 4*2^MEM_ADDR_WIDTH, compared in 33-bit arithmetic so that no wrap-around occurs.
REQ-020 In-range selected request: mem_req_o=1, mem_we_o=~wen, mem_addr_o=(addr-BASE_ADDR)>>2, and wdata/be passed through; the channel gnt_o SHALL equal mem_gnt_i.
REQ-021 Address bits [1:0] SHALL be ignored; byte selection is carried by be only.
REQ-022 Out-of-range selected request: gnt_o=1 regardless of mem_gnt_i; mem_req_o=0; no memory write occurs.
REQ-023 Response data, in the rvalid cycle:
- in-range read: rdata_o = mem_rdata_i;
- out-of-range read: rdata_o = 32'hBADACCE5 (zero-extended or truncated to DATA_WIDTH);
- any write: rdata_o = 0.
REQ-024 rdata_o SHALL be 0 whenever rvalid_o=0.
REQ-025 A request that is not granted (lost arbitration or mem_gnt_i=0) SHALL receive no rvalid; the requester holds its request and the arbitration pointer is unchanged.
REQ-026 Back-to-back grants every cycle to either channel SHALL be sustained; rvalid/rdata for grant N appear in cycle N+1 concurrently with grant N+1.
REQ-027 err_cnt_o SHALL increment by 1 per granted out-of-range access and saturate at 16'hFFFF.
REQ-028 err_clr_i=1 SHALL set err_cnt_o to 0 next cycle, taking priority over a simultaneous increment.

Reset
REQ-029 sys_rst_i=1 at a clock edge SHALL clear:
- the pending-response registers, so no rvalid follows a grant given in the reset cycle;
- the last-grant pointer to "wo", so the first tie goes to ro;
- err_cnt_o to 0.
REQ-030 While sys_rst_i=1, gnt_o, mem_req_o and rvalid_o on all channels SHALL be 0.

Verification
REQ-031 ro read, addr 32'h1C00_0010, mem_gnt_i=1 -> same cycle: ro_gnt=1, mem_addr=4, mem_we=0; next cycle: ro_rvalid=1, ro_rdata=mem_rdata_i.
REQ-032 Both channels request for 4 cycles, mem_gnt_i=1 -> grants alternate ro, wo, ro, wo; each rvalid lands on the correct channel one cycle later.
REQ-033 wo write, addr 32'h1C00_0004, be=4'b0011, data 32'hDEADBEEF, mem_gnt_i=0 for 2 cycles then 1 -> no gnt for 2 cycles; then gnt with mem_we=1, mem_addr=1, be=0011; rvalid next cycle with rdata=0.
REQ-034 ro read, addr 32'h0000_0000 -> gnt=1, mem_req=0; next cycle rvalid=1, rdata=32'hBADACCE5, err_cnt=1; then err_clr_i=1 together with another bad access -> err_cnt=0.
REQ-035 sys_rst_i asserted in the same cycle as a granted ro read -> no rvalid the next cycle; the first post-reset tie is granted to ro.
REQ-036 Inject 65540 out-of-range accesses -> err_cnt_o holds 16'hFFFF.
